// File: rtl/axis_frame_tagger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_frame_tagger                                                          |
// | Re-frames a pixel stream with SOF on TUSER / EOL on TLAST, checks input    |
// | TLAST, and drives registered outputs from a two-entry skid buffer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axis_frame_tagger #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DWIDTH-1:0]     S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DWIDTH-1:0]     M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TUSER,
  output logic [DWIDTH/8-1:0]   M_AXIS_TKEEP,
  input  logic                  clear_errors,
  output logic [31:0]           frame_count,
  output logic                  err_early_last,
  output logic                  err_missing_last
);

  localparam int c_col_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_row_w = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(WIDTH - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(HEIGHT - 1);

  logic [c_col_w-1:0] col_q, col_d;
  logic [c_row_w-1:0] row_q, row_d;
  logic [31:0]        frame_count_q, frame_count_d;
  logic               err_early_q, err_early_d;
  logic               err_missing_q, err_missing_d;

  logic               main_valid_q, main_valid_d;
  logic [DWIDTH-1:0]  main_data_q, main_data_d;
  logic               main_last_q, main_last_d;
  logic               main_user_q, main_user_d;
  logic               skid_valid_q, skid_valid_d;
  logic [DWIDTH-1:0]  skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;
  logic               skid_user_q, skid_user_d;

  logic accept;
  logic main_free;
  logic at_last_col;
  logic at_last_row;
  logic early;
  logic tag_last;
  logic tag_user;

  always_comb begin
    accept      = S_AXIS_TVALID & ~skid_valid_q;
    main_free   = ~main_valid_q | M_AXIS_TREADY;
    at_last_col = (col_q == c_last_col);
    at_last_row = (row_q == c_last_row);
    early       = S_AXIS_TLAST & ~at_last_col;
    tag_last    = at_last_col | early;
    tag_user    = (col_q == '0) & (row_q == '0);

    col_d         = col_q;
    row_d         = row_q;
    frame_count_d = frame_count_q;
    err_early_d   = err_early_q;
    err_missing_d = err_missing_q;
    main_valid_d  = main_valid_q;
    main_data_d   = main_data_q;
    main_last_d   = main_last_q;
    main_user_d   = main_user_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_last_d   = skid_last_q;
    skid_user_d   = skid_user_q;

    // An early TLAST closes the line, so framing resynchronises on it.
    if (accept) begin
      if (tag_last) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + c_row_w'(1);
        if (at_last_row) begin
          frame_count_d = frame_count_q + 32'd1;
        end
      end else begin
        col_d = col_q + c_col_w'(1);
      end
    end

    // Clear first so that a simultaneous new error wins.
    if (clear_errors) begin
      err_early_d   = 1'b0;
      err_missing_d = 1'b0;
    end
    if (accept & early) begin
      err_early_d = 1'b1;
    end
    if (accept & at_last_col & ~S_AXIS_TLAST) begin
      err_missing_d = 1'b1;
    end

    // Skid can only be occupied while main is, and input is blocked meanwhile.
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_user_d  = skid_user_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = S_AXIS_TDATA;
          main_last_d = tag_last;
          main_user_d = tag_user;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = S_AXIS_TDATA;
      skid_last_d  = tag_last;
      skid_user_d  = tag_user;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      main_valid_q  <= 1'b0;
      main_data_q   <= '0;
      main_last_q   <= 1'b0;
      main_user_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
      skid_user_q   <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      main_valid_q  <= main_valid_d;
      main_data_q   <= main_data_d;
      main_last_q   <= main_last_d;
      main_user_q   <= main_user_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_last_q   <= skid_last_d;
      skid_user_q   <= skid_user_d;
    end
  end

  assign S_AXIS_TREADY    = ~skid_valid_q;
  assign M_AXIS_TVALID    = main_valid_q;
  assign M_AXIS_TDATA     = main_data_q;
  assign M_AXIS_TLAST     = main_last_q;
  assign M_AXIS_TUSER     = main_user_q;
  assign M_AXIS_TKEEP     = '1;
  assign frame_count      = frame_count_q;
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_missing_q;

endmodule
`default_nettype wire

// File: doc/axis_frame_tagger.md
# axis_frame_tagger

Downstream stage of the Life pipeline top: consumes the processed pixel stream from its master AXI-Stream port and re-emits it with video framing for the VDMA S2MM channel. Maintains column/row counters and marks start-of-frame on TUSER and end-of-line on TLAST. Checks incoming TLAST against the expected line length and reports sticky errors. A two-entry skid buffer gives registered outputs at one beat per cycle.

## Interface
- DWIDTH, 32, pixel word width in bits (multiple of 8)
- WIDTH, 8, pixels per line (>= 1)
- HEIGHT, 1, lines per frame (>= 1)

- ACLK  in  1  clock; everything is on the rising edge
- ARESET  in  1  reset; synchronous, active-high
- S_AXIS_TVALID  in  1  input beat valid
- S_AXIS_TREADY  out  1  input beat ready
- S_AXIS_TDATA  in  DWIDTH  input pixel word
- S_AXIS_TLAST  in  1  upstream end-of-line marker; checked only, never forwarded
- M_AXIS_TVALID  out  1  output beat valid
- M_AXIS_TREADY  in  1  output beat ready
- M_AXIS_TDATA  out  DWIDTH  pixel word, unmodified
- M_AXIS_TLAST  out  1  end-of-line, generated from the counters
- M_AXIS_TUSER  out  1  start-of-frame, generated from the counters
- M_AXIS_TKEEP  out  DWIDTH/8  constant all-ones
- clear_errors  in  1  single-cycle pulse; clears the sticky error flags
- frame_count  out  32  number of complete frames accepted on the input
- err_early_last  out  1  sticky: S_AXIS_TLAST seen before the last column
- err_missing_last  out  1  sticky: last column accepted without S_AXIS_TLAST

## Operation
- Input accept = S_AXIS_TVALID & S_AXIS_TREADY. Output transfer = M_AXIS_TVALID & M_AXIS_TREADY.
- Counters:
  - col runs 0..WIDTH-1; row runs 0..HEIGHT-1.
  - Each counter is max(1, $clog2(N)) bits wide.
  - Both counters update only on input accept.
- Tag computation at input accept:
  - tuser = (col==0 && row==0).
  - tlast = (col==WIDTH-1) | early, where early = S_AXIS_TLAST & (col != WIDTH-1).
  - Tags are stored alongside TDATA in the buffer.
- Counter advance on accept:
  - If tlast: col <- 0; row <- (row==HEIGHT-1) ? 0 : row+1.
  - Otherwise: col <- col+1.
  - An early TLAST therefore resynchronises line framing. The truncated line is still emitted with TLAST=1.
- frame_count increments on accept when tlast && row==HEIGHT-1. It wraps modulo 2^32.
- Error flags:
  - err_early_last is set on accept when early=1.
  - err_missing_last is set on accept when col==WIDTH-1 && !S_AXIS_TLAST. The output TLAST is still asserted for that beat.
  - clear_errors clears both flags. If clear_errors and a new error happen in the same cycle, the set wins.
- Skid buffer: a main output register plus one skid register.
  - S_AXIS_TREADY = !skid_valid. It is driven from a register and has no combinational path from M_AXIS_TREADY.
  - Accept while the main register is empty or transferring: the beat loads the main register.
  - Accept while the main register is stalled: the beat loads the skid register.
  - On transfer with skid_valid set: skid moves into the main register and skid_valid clears.
- Special cases:
  - WIDTH=1: every beat carries TLAST=1.
  - HEIGHT=1: every line's first beat carries TUSER=1.

## Timing
- Reset values (sampled with ARESET=1 on the ACLK edge):
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TUSER=0, M_AXIS_TDATA=0.
  - S_AXIS_TREADY=1 from the first cycle after reset.
  - col=0, row=0, frame_count=0, both error flags 0.
  - Both buffer entries empty.
- Reset mid-frame:
  - Buffered beats are discarded and never emitted.
  - The next accepted beat carries TUSER=1.
- Latency: an input accept at edge N gives M_AXIS_TVALID=1 after edge N, provided the main register was empty.
- Throughput: 1 beat/cycle sustained while M_AXIS_TREADY=1.
- Backpressure: with M_AXIS_TREADY=0, at most 2 beats are held. S_AXIS_TREADY drops after the second is accepted.
- Output rules: M_AXIS_TVALID and payload stay stable until transfer. No beat is lost, duplicated or reordered.
- Status timing: frame_count and error flags change on the edge after the triggering accept.

## Test plan
- Reset check (WIDTH=4, HEIGHT=2): hold ARESET 3 cycles -> all outputs at the listed reset values; S_AXIS_TREADY=1 afterwards.
- Clean frames: 2 frames, data 0..15, input TLAST on every 4th beat, M_AXIS_TREADY=1 ->
  - TUSER on beats 0 and 8; TLAST on beats 3, 7, 11, 15.
  - Data in order; frame_count=2; no errors.
- Early TLAST: input TLAST on beat 1 (col 1) ->
  - Output beat 1 has TLAST=1 and err_early_last=1.
  - Next beat is col 0 of row 1, TUSER=0.
- Missing TLAST: beat 3 without input TLAST ->
  - Output TLAST=1 on beat 3 and err_missing_last=1.
  - clear_errors pulse -> flag returns to 0. A pulse coinciding with a new error leaves the flag at 1.
- Backpressure: random M_AXIS_TREADY (50%) over 1000 beats ->
  - Output sequence equals input sequence.
  - S_AXIS_TREADY is 0 only while 2 beats are buffered.
  - Payload is stable while stalled.
- Reset mid-frame: ARESET after 6 beats with 2 beats buffered ->
  - The 2 buffered beats are never emitted.
  - The next accepted beat has TUSER=1; frame_count=0.
